// File: rtl/signal_debounce.sv
// Debouncer for a raw asynchronous input: 2-flop synchronizer, STABLE/VERIFY FSM,
// registered debounced level, busy flag and saturating glitch counter.
module signal_debounce #(
   parameter int unsigned CNT_MAX   = 1000000,
   parameter logic        RST_LEVEL = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_in,
   input  logic       glitch_clr,
   output logic       D_signal,
   output logic       busy,
   output logic [7:0] glitch_cnt
);

   localparam int unsigned CW = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
   localparam logic [CW-1:0] CntLast = CW'(CNT_MAX - 1);

   typedef enum logic {StStable, StVerify} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          s1_q, s2_q;
   logic          level_q, level_d;
   logic          busy_q;
   logic [7:0]    glitch_q, glitch_d;
   logic          reject;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      reject  = 1'b0;
      unique case (state_q)
         StStable: begin
            cnt_d = '0;
            if (s2_q != level_q) state_d = StVerify;
         end
         StVerify: begin
            if (s2_q == level_q) begin
               // Input bounced back before the stable window completed
               state_d = StStable;
               cnt_d   = '0;
               reject  = 1'b1;
            end else if (cnt_q == CntLast) begin
               level_d = s2_q;
               state_d = StStable;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = StStable;
      endcase
   end

   always_comb begin
      glitch_d = glitch_q;
      if (glitch_clr) begin
         glitch_d = '0;
      end else if (reject && (glitch_q != 8'hFF)) begin
         glitch_d = glitch_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q     <= RST_LEVEL;
         s2_q     <= RST_LEVEL;
         level_q  <= RST_LEVEL;
         state_q  <= StStable;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         glitch_q <= '0;
      end else begin
         s1_q     <= key_in;
         s2_q     <= s1_q;
         level_q  <= level_d;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         busy_q   <= (state_d == StVerify);
         glitch_q <= glitch_d;
      end
   end

   assign D_signal   = level_q;
   assign busy       = busy_q;
   assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_signal_debounce.sv
// Self-checking bench for signal_debounce: vector table, hand-written corner sequences
// and randomized stimulus against a run-length reference model.
module tb_signal_debounce;

   localparam int unsigned CNT_MAX = 4;

   logic       clk;
   logic       rst_n;
   logic       key_in;
   logic       glitch_clr;
   logic       D_signal;
   logic       busy;
   logic [7:0] glitch_cnt;

   int total = 0;
   int bad   = 0;

   // Reference model: sync pipeline plus length of the current run of differing samples
   bit m_s1, m_s2, m_d;
   int m_run, m_g;

   typedef struct {
      bit rst;
      bit key;
      bit clr;
      bit d;
      bit bsy;
      int g;
   } vec_t;

   vec_t tbl[$];

   signal_debounce #(
      .CNT_MAX  (CNT_MAX),
      .RST_LEVEL(1'b0)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_in    (key_in),
      .glitch_clr(glitch_clr),
      .D_signal  (D_signal),
      .busy      (busy),
      .glitch_cnt(glitch_cnt)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_s1 = 1'b0; m_s2 = 1'b0; m_d = 1'b0; m_run = 0; m_g = 0;
   endtask

   task automatic model_edge();
      if (m_s2 != m_d) begin
         m_run++;
         if (m_run == CNT_MAX + 1) begin
            m_d   = m_s2;
            m_run = 0;
         end
      end else begin
         if (m_run > 0 && m_g < 255) m_g++;
         m_run = 0;
      end
      if (glitch_clr) m_g = 0;
      m_s2 = m_s1;
      m_s1 = key_in;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #5;
      rst_n = 1'b1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   int rises, falls;
   bit prev_d;

   initial begin
      rst_n = 1'b1; key_in = 1'b0; glitch_clr = 1'b0;
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("reset_d", D_signal, 0);
      chk("reset_busy", busy, 0);
      chk("reset_glitch", glitch_cnt, 0);
      rst_n = 1'b1;

      // Clean step: busy from edge 3, acceptance at edge 7
      tbl.push_back('{1, 1, 0, 0, 0, 0});
      tbl.push_back('{0, 1, 0, 0, 0, 0});
      tbl.push_back('{0, 1, 0, 0, 1, 0});
      tbl.push_back('{0, 1, 0, 0, 1, 0});
      tbl.push_back('{0, 1, 0, 0, 1, 0});
      tbl.push_back('{0, 1, 0, 0, 1, 0});
      tbl.push_back('{0, 1, 0, 1, 0, 0});
      tbl.push_back('{0, 1, 0, 1, 0, 0});
      // 3-cycle bounce is rejected at edge 6
      tbl.push_back('{1, 1, 0, 0, 0, 0});
      tbl.push_back('{0, 1, 0, 0, 0, 0});
      tbl.push_back('{0, 1, 0, 0, 1, 0});
      tbl.push_back('{0, 0, 0, 0, 1, 0});
      tbl.push_back('{0, 0, 0, 0, 1, 0});
      tbl.push_back('{0, 0, 0, 0, 0, 1});
      tbl.push_back('{0, 0, 0, 0, 0, 1});
      tbl.push_back('{0, 0, 0, 0, 0, 1});
      tbl.push_back('{0, 0, 1, 0, 0, 0});

      foreach (tbl[i]) begin
         if (tbl[i].rst) do_reset();
         key_in     = tbl[i].key;
         glitch_clr = tbl[i].clr;
         tick();
         chk($sformatf("vec%0d_d", i), D_signal, tbl[i].d);
         chk($sformatf("vec%0d_busy", i), busy, tbl[i].bsy);
         chk($sformatf("vec%0d_glitch", i), glitch_cnt, tbl[i].g);
      end
      glitch_clr = 1'b0;

      // Burst of five 2-cycle pulses, then held high
      do_reset();
      for (int p = 0; p < 5; p++) begin
         key_in = 1'b1; ticks(2);
         key_in = 1'b0; ticks(2);
      end
      key_in = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         tick();
         if (e == 6) chk("burst_d_edge6", D_signal, 0);
      end
      chk("burst_d_edge7", D_signal, 1);
      chk("burst_glitch", glitch_cnt, 5);

      // Reset in the middle of verification
      do_reset();
      key_in = 1'b0; ticks(3);
      key_in = 1'b1; ticks(4);
      chk("midrst_busy_before", busy, 1);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("midrst_d", D_signal, 0);
      chk("midrst_busy", busy, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         tick();
         if (e == 6) chk("midrst_d_edge6", D_signal, 0);
      end
      chk("midrst_d_edge7", D_signal, 1);

      // Saturation, then clear colliding with a rejection
      do_reset();
      key_in = 1'b0;
      for (int p = 0; p < 260; p++) begin
         key_in = 1'b1; tick();
         key_in = 1'b0; ticks(4);
      end
      chk("sat_glitch", glitch_cnt, 255);
      chk("sat_d", D_signal, 0);
      key_in = 1'b1; tick();
      key_in = 1'b0; ticks(2);
      chk("clr_busy_pre", busy, 1);
      glitch_clr = 1'b1;
      tick();
      glitch_clr = 1'b0;
      chk("clr_collide_glitch", glitch_cnt, 0);
      chk("clr_collide_busy", busy, 0);

      // Bouncy 0->1->0: downstream edge detector must see one rise and one fall
      do_reset();
      key_in = 1'b0; ticks(3);
      rises = 0; falls = 0; prev_d = D_signal;
      begin
         bit seq[$];
         seq = '{1,0,1,1,0,1,0,0,1,1,1,1,1,1,1,1,1,1,1,1,
                 0,1,0,0,1,0,1,1,0,0,0,0,0,0,0,0,0,0,0,0};
         foreach (seq[i]) begin
            key_in = seq[i];
            tick();
            if (!prev_d && D_signal) rises++;
            if (prev_d && !D_signal) falls++;
            prev_d = D_signal;
         end
      end
      chk("chain_pos_edges", rises, 1);
      chk("chain_neg_edges", falls, 1);
      chk("chain_final_d", D_signal, 0);

      // Randomized runs against the model
      do_reset();
      for (int n = 0; n < 120; n++) begin
         int len;
         bit val;
         len = $urandom_range(1, 8);
         val = 1'($urandom_range(0, 1));
         for (int k = 0; k < len; k++) begin
            key_in     = val;
            glitch_clr = ($urandom_range(0, 15) == 0);
            tick();
            chk("rand_d", D_signal, m_d);
            chk("rand_busy", busy, (m_run > 0) ? 1 : 0);
            chk("rand_glitch", glitch_cnt, m_g);
         end
      end
      glitch_clr = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
